// File: rtl/dm_pkg.sv
// Shared encodings for the data-memory access controller: op size codes,
// the load-extension bit position and the controller state encoding.
package dm_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_INV  = 2'b11;

    localparam int OP_UNSIGNED_BIT = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_READ  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERR   = 3'd5
    } dm_state_t;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] byte_off);
        case (size)
            SZ_HALF: return byte_off[0];
            SZ_WORD: return (byte_off != 2'b00);
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dm_lane_unit.sv
// Lane steering for sub-word accesses: extracts and extends load data, and
// merges store data into the old word. One lane decode feeds both paths.
module dm_lane_unit
    import dm_pkg::*;
(
    input  logic [1:0]  byte_off,
    input  logic [2:0]  op,
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);

    logic [1:0]  lane_off;
    logic [3:0]  lane_en;
    logic [31:0] wdata_rep;
    logic [31:0] shifted;

    always_comb begin
        lane_off  = 2'b00;
        lane_en   = 4'b1111;
        wdata_rep = wdata;
        case (op[1:0])
            SZ_BYTE: begin
                lane_off  = byte_off;
                lane_en   = 4'b0001 << byte_off;
                wdata_rep = {4{wdata[7:0]}};
            end
            SZ_HALF: begin
                lane_off  = {byte_off[1], 1'b0};
                lane_en   = byte_off[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata[15:0]}};
            end
            default: begin
                lane_off  = 2'b00;
                lane_en   = 4'b1111;
                wdata_rep = wdata;
            end
        endcase
    end

    assign shifted = old_word >> {lane_off, 3'b000};

    always_comb begin
        load_data = shifted;
        case (op[1:0])
            SZ_BYTE: load_data = op[OP_UNSIGNED_BIT] ? {24'h0, shifted[7:0]}
                                                     : {{24{shifted[7]}}, shifted[7:0]};
            SZ_HALF: load_data = op[OP_UNSIGNED_BIT] ? {16'h0, shifted[15:0]}
                                                     : {{16{shifted[15]}}, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

    always_comb begin
        merge_data = old_word;
        for (int k = 0; k < 4; k++) begin
            if (lane_en[k]) begin
                merge_data[8*k +: 8] = wdata_rep[8*k +: 8];
            end
        end
    end

endmodule

// File: rtl/dm_access_ctrl.sv
// MEM-stage to data-memory access controller (byte/half/word, RMW for sub-word stores).
// Optional build macro DM_RANGE_CHECK_EN adds an out-of-window address error.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for req; request fields latched on accept
// ST_LOAD  | memory read, extended result captured into rdata
// ST_READ  | old word read and merged with store lanes
// ST_WRITE | dm_we asserted with full word on dm_din
// ST_DONE  | done pulse, access completed normally
// ST_ERR   | done pulse with addr_err, no memory side effects
module dm_access_ctrl
    import dm_pkg::*;
#(
    parameter int          DM_AW     = 10,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req,
    input  logic             we,
    input  logic [2:0]       op,
    input  logic [31:0]      addr,
    input  logic [31:0]      wdata,
    output logic             busy,
    output logic             done,
    output logic             addr_err,
    output logic [31:0]      rdata,
    output logic [DM_AW-1:0] dm_addr,
    output logic [31:0]      dm_din,
    output logic             dm_we,
    input  logic [31:0]      dm_dout
);

    dm_state_t         state, state_nxt;
    logic [2:0]        op_q;
    logic [DM_AW+1:0]  addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       dm_din_q;
    logic [31:0]       rdata_q;
    logic [31:0]       load_data;
    logic [31:0]       merge_data;
    logic              out_of_range;
    logic              bad_req;

`ifdef DM_RANGE_CHECK_EN
    localparam logic [32:0] MEM_BYTES = 33'd4 << DM_AW;
    logic [32:0] addr_ext;
    logic [32:0] base_ext;
    assign addr_ext     = {1'b0, addr};
    assign base_ext     = {1'b0, BASE_ADDR};
    assign out_of_range = (addr_ext < base_ext) || (addr_ext >= (base_ext + MEM_BYTES));
`else
    // Upper address bits are intentionally dropped so accesses wrap.
    logic unused_range;
    assign unused_range = ^{addr[31:DM_AW+2], BASE_ADDR};
    assign out_of_range = 1'b0;
`endif

    assign bad_req = (op[1:0] == SZ_INV) || is_misaligned(op[1:0], addr[1:0]) || out_of_range;

    dm_lane_unit u_lane (
        .byte_off   (addr_q[1:0]),
        .op         (op_q),
        .old_word   (dm_dout),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .merge_data (merge_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        done      = 1'b0;
        addr_err  = 1'b0;
        dm_we     = 1'b0;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (req) begin
                    if (bad_req)                  state_nxt = ST_ERR;
                    else if (!we)                 state_nxt = ST_LOAD;
                    else if (op[1:0] == SZ_WORD)  state_nxt = ST_WRITE;
                    else                          state_nxt = ST_READ;
                end
            end
            ST_LOAD:  state_nxt = ST_DONE;
            ST_READ:  state_nxt = ST_WRITE;
            ST_WRITE: begin
                dm_we     = 1'b1;
                state_nxt = ST_DONE;
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            ST_ERR: begin
                done      = 1'b1;
                addr_err  = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                busy      = 1'b0;
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // dm_din_q doubles as the merge register; it only changes on entry to WRITE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            dm_din_q <= '0;
            rdata_q  <= '0;
        end else begin
            if (state == ST_IDLE && req) begin
                op_q    <= op;
                addr_q  <= addr[DM_AW+1:0];
                wdata_q <= wdata;
            end
            if (state == ST_IDLE && state_nxt == ST_WRITE) begin
                dm_din_q <= wdata;
            end
            if (state == ST_READ) begin
                dm_din_q <= merge_data;
            end
            if (state == ST_LOAD) begin
                rdata_q <= load_data;
            end
        end
    end

    assign dm_addr = addr_q[DM_AW+1:2];
    assign dm_din  = dm_din_q;
    assign rdata   = rdata_q;

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Self-checking bench for dm_access_ctrl with a behavioural 4 KB memory and
// a result scoreboard popped on every done pulse.
module tb_dm_access_ctrl;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic [3:0]  lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [2:0]  op = 3'b000;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        busy, done, addr_err, dm_we;
    logic [31:0] rdata, dm_din, dm_dout;
    logic [9:0]  dm_addr;

    logic [31:0] mem [0:1023];
    logic        pl_en = 1'b0;
    logic [9:0]  pl_idx = 10'h0;
    logic [31:0] pl_val = 32'h0;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          start_cyc = 0;
    logic        prev_busy = 1'b0;
    logic [31:0] exp_rdata = 32'h0;

    dm_access_ctrl #(.DM_AW(10), .BASE_ADDR(32'h0000_0000)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .we       (we),
        .op       (op),
        .addr     (addr),
        .wdata    (wdata),
        .busy     (busy),
        .done     (done),
        .addr_err (addr_err),
        .rdata    (rdata),
        .dm_addr  (dm_addr),
        .dm_din   (dm_din),
        .dm_we    (dm_we),
        .dm_dout  (dm_dout)
    );

    always #5 clk = ~clk;

    assign dm_dout = mem[dm_addr];

    always @(posedge clk) begin
        if (pl_en) mem[pl_idx] <= pl_val;
        else if (dm_we) mem[dm_addr] <= dm_din;
    end

    always @(posedge clk) cyc++;

    // Scoreboard: every done pulse pops one expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_busy = 1'b0;
        end else begin
            if (busy && !prev_busy) start_cyc = cyc - 1;
            prev_busy = busy;
            if (done) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected_done: done seen with rdata=%h err=%b, required no done", rdata, addr_err);
                end else begin
                    e = exp_q.pop_front();
                    if (rdata !== e.rdata || addr_err !== e.err || (cyc - start_cyc) != int'(e.lat)) begin
                        n_fail++;
                        $display("FAIL sb_result: got rdata=%h err=%b lat=%0d, required rdata=%h err=%b lat=%0d",
                                 rdata, addr_err, cyc - start_cyc, e.rdata, e.err, e.lat);
                    end
                end
            end
        end
    end

    function automatic void push_exp(input logic [31:0] r, input logic e, input int lat);
        exp_t x;
        x.rdata = r;
        x.err   = e;
        x.lat   = 4'(lat);
        exp_q.push_back(x);
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [2:0] o, input logic [1:0] a);
        logic [7:0]  b;
        logic [15:0] h;
        case (a)
            2'd0: b = w[7:0];
            2'd1: b = w[15:8];
            2'd2: b = w[23:16];
            default: b = w[31:24];
        endcase
        h = a[1] ? w[31:16] : w[15:0];
        case (o[1:0])
            2'b00: return o[2] ? {24'h0, b} : {{24{b[7]}}, b};
            2'b01: return o[2] ? {16'h0, h} : {{16{h[15]}}, h};
            default: return w;
        endcase
    endfunction

    task automatic preload(input logic [9:0] idx, input logic [31:0] val);
        @(negedge clk);
        pl_en = 1'b1; pl_idx = idx; pl_val = val;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    task automatic issue(input logic w, input logic [2:0] o, input logic [31:0] a, input logic [31:0] d,
                         output int we_n, output int we_at, output int busy_n);
        logic seen;
        @(negedge clk);
        req = 1'b1; we = w; op = o; addr = a; wdata = d;
        @(posedge clk);
        #1 req = 1'b0;
        we_n = 0; we_at = 0; busy_n = 0; seen = 1'b0;
        for (int i = 1; i <= 10 && !seen; i++) begin
            @(negedge clk);
            if (dm_we) begin we_n++; we_at = i; end
            if (busy) busy_n++;
            if (done) seen = 1'b1;
        end
        if (!seen) begin
            n_checks++; n_fail++;
            $display("FAIL issue_timeout: no done within 10 cycles for addr=%h op=%b we=%b", a, o, w);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_checks++;
        if ({busy, done, addr_err, dm_we} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_ctrl: busy/done/err/we=%b, required 0000", {busy, done, addr_err, dm_we});
        end
        n_checks++;
        if (rdata !== 32'h0 || dm_din !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_data: rdata=%h dm_din=%h, required 0 and 0", rdata, dm_din);
        end
        n_checks++;
        if (dm_addr !== 10'h0) begin
            n_fail++;
            $display("FAIL reset_addr: dm_addr=%h, required 0", dm_addr);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_load();
        int wn, wa, bn;
        exp_rdata = 32'hFFFFFF88; push_exp(exp_rdata, 1'b0, 2);
        issue(1'b0, 3'b000, 32'h13, 32'h0, wn, wa, bn);
        n_checks++;
        if (wn != 0 || bn != 2) begin
            n_fail++;
            $display("FAIL lb_side: we_cycles=%0d busy_cycles=%0d, required 0 and 2", wn, bn);
        end
        exp_rdata = 32'h00000099; push_exp(exp_rdata, 1'b0, 2);
        issue(1'b0, 3'b100, 32'h12, 32'h0, wn, wa, bn);
        for (int k = 0; k < 4; k++) begin
            exp_rdata = ref_load(32'h8899AABB, 3'b000, 2'(k)); push_exp(exp_rdata, 1'b0, 2);
            issue(1'b0, 3'b000, 32'h10 + 32'(k), 32'h0, wn, wa, bn);
            exp_rdata = ref_load(32'h8899AABB, 3'b100, 2'(k)); push_exp(exp_rdata, 1'b0, 2);
            issue(1'b0, 3'b100, 32'h10 + 32'(k), 32'h0, wn, wa, bn);
        end
        exp_rdata = 32'hFFFFAABB; push_exp(exp_rdata, 1'b0, 2);
        issue(1'b0, 3'b001, 32'h10, 32'h0, wn, wa, bn);
        exp_rdata = 32'h00008899; push_exp(exp_rdata, 1'b0, 2);
        issue(1'b0, 3'b101, 32'h12, 32'h0, wn, wa, bn);
        exp_rdata = 32'h8899AABB; push_exp(exp_rdata, 1'b0, 2);
        issue(1'b0, 3'b110, 32'h10, 32'h0, wn, wa, bn);
    endtask

    task automatic test_store_half();
        int wn, wa, bn;
        push_exp(exp_rdata, 1'b0, 3);
        issue(1'b1, 3'b001, 32'h12, 32'h00001234, wn, wa, bn);
        n_checks++;
        if (wn != 1 || wa != 2 || bn != 3) begin
            n_fail++;
            $display("FAIL sh_timing: we_cycles=%0d we_at=%0d busy=%0d, required 1, 2, 3", wn, wa, bn);
        end
        n_checks++;
        if (mem[4] !== 32'h1234AABB) begin
            n_fail++;
            $display("FAIL sh_word: mem=%h, required 1234aabb", mem[4]);
        end
        exp_rdata = 32'h1234AABB; push_exp(exp_rdata, 1'b0, 2);
        issue(1'b0, 3'b010, 32'h10, 32'h0, wn, wa, bn);
    endtask

    task automatic test_store_word();
        int wn, wa, bn;
        push_exp(exp_rdata, 1'b0, 2);
        issue(1'b1, 3'b010, 32'hFFC, 32'hDEADBEEF, wn, wa, bn);
        n_checks++;
        if (wn != 1 || wa != 1 || bn != 2) begin
            n_fail++;
            $display("FAIL sw_timing: we_cycles=%0d we_at=%0d busy=%0d, required 1, 1, 2", wn, wa, bn);
        end
        n_checks++;
        if (mem[1023] !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL sw_word: mem=%h, required deadbeef", mem[1023]);
        end
        exp_rdata = 32'hFFFFDEAD; push_exp(exp_rdata, 1'b0, 2);
        issue(1'b0, 3'b001, 32'hFFE, 32'h0, wn, wa, bn);
    endtask

    task automatic test_store_byte();
        int wn, wa, bn;
        push_exp(exp_rdata, 1'b0, 3);
        issue(1'b1, 3'b000, 32'h11, 32'hFFFFFF5A, wn, wa, bn);
        n_checks++;
        if (mem[4] !== 32'h12345ABB) begin
            n_fail++;
            $display("FAIL sb_word: mem=%h, required 12345abb", mem[4]);
        end
        exp_rdata = 32'h0000005A; push_exp(exp_rdata, 1'b0, 2);
        issue(1'b0, 3'b100, 32'h11, 32'h0, wn, wa, bn);
    endtask

    task automatic test_misaligned();
        int wn, wa, bn;
        push_exp(exp_rdata, 1'b1, 1);
        issue(1'b0, 3'b010, 32'h21, 32'h0, wn, wa, bn);
        n_checks++;
        if (wn != 0 || bn != 1) begin
            n_fail++;
            $display("FAIL lw_misaligned_side: we_cycles=%0d busy=%0d, required 0 and 1", wn, bn);
        end
        push_exp(exp_rdata, 1'b1, 1);
        issue(1'b1, 3'b001, 32'h21, 32'h0000FFFF, wn, wa, bn);
        n_checks++;
        if (wn != 0) begin
            n_fail++;
            $display("FAIL sh_misaligned_we: we_cycles=%0d, required 0", wn);
        end
        push_exp(exp_rdata, 1'b1, 1);
        issue(1'b1, 3'b011, 32'h10, 32'h0BADBAD0, wn, wa, bn);
        n_checks++;
        if (wn != 0 || mem[4] !== 32'h12345ABB) begin
            n_fail++;
            $display("FAIL op_invalid: we_cycles=%0d mem=%h, required 0 and 12345abb", wn, mem[4]);
        end
    endtask

    task automatic test_back_to_back();
        logic seen;
        @(negedge clk);
        req = 1'b1; we = 1'b0; op = 3'b010; addr = 32'h10;
        exp_rdata = 32'h12345ABB; push_exp(exp_rdata, 1'b0, 2);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        op = 3'b100; addr = 32'h13;
        exp_rdata = 32'h00000012; push_exp(exp_rdata, 1'b0, 2);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        req = 1'b0;
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL b2b_timeout: second done seen=%b, required 1", seen);
        end
    endtask

    task automatic test_range();
        int wn, wa, bn;
`ifdef DM_RANGE_CHECK_EN
        push_exp(exp_rdata, 1'b1, 1);
`else
        exp_rdata = 32'h13579BDF; push_exp(exp_rdata, 1'b0, 2);
`endif
        issue(1'b0, 3'b010, 32'h1000, 32'h0, wn, wa, bn);
    endtask

    task automatic test_reset_abort();
        int wn, wa, bn;
        @(negedge clk);
        req = 1'b1; we = 1'b1; op = 3'b000; addr = 32'h41; wdata = 32'h77;
        @(posedge clk);
        #1 req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (dm_we !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_pre_we: dm_we=%b, required 1", dm_we);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (dm_we !== 1'b0 || busy !== 1'b0 || rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL abort_outputs: we=%b busy=%b rdata=%h, required 0, 0, 0", dm_we, busy, rdata);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (mem[16] !== 32'hCAFEF00D) begin
            n_fail++;
            $display("FAIL abort_word: mem=%h, required cafef00d", mem[16]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp_rdata = 32'hCAFEF00D; push_exp(exp_rdata, 1'b0, 2);
        issue(1'b0, 3'b010, 32'h40, 32'h0, wn, wa, bn);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        preload(10'd4, 32'h8899AABB);
        preload(10'd0, 32'h13579BDF);
        preload(10'd16, 32'hCAFEF00D);
        preload(10'd1023, 32'h0);
        test_load();
        test_store_half();
        test_store_word();
        test_store_byte();
        test_misaligned();
        test_back_to_back();
        test_range();
        test_reset_abort();
        repeat (3) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_leftover: %0d expectations pending, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dm_access_ctrl.md
Name: dm_access_ctrl

Overview:
- Initiator-side controller between the MEM pipeline stage and the 4 KB word-addressed data memory (word address, din, write-enable, combinational dout).
- Converts byte/halfword/word loads and stores into word accesses.
- Sub-word stores use a 2-cycle read-modify-write because the memory writes whole words only.
- Reports completion with `done` and raises `busy` so the pipeline can stall; flags misaligned accesses.

Parameters:
- DM_AW, 10, word-address width driven to the memory (1024 words).
- BASE_ADDR, 32'h0000_0000, byte address of memory word 0. Used only by the optional range check.

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  asynchronous active-low reset
- req  in  1  access request from MEM stage
- we  in  1  1 = store, 0 = load
- op  in  3  op[1:0]: 00 byte, 01 half, 10 word, 11 invalid; op[2]=1 zero-extend on load
- addr  in  32  byte address
- wdata  in  32  store data, right-aligned for sb/sh
- busy  out  1  controller not IDLE
- done  out  1  one-cycle completion pulse
- addr_err  out  1  valid with done; access aborted
- rdata  out  32  extended load result; holds until next load completes
- dm_addr  out  DM_AW  word address to memory
- dm_din  out  32  write data to memory
- dm_we  out  1  memory write enable
- dm_dout  in  32  memory read data (combinational)

Behaviour:
- Reset (async): state=IDLE, all latches cleared.
  - Outputs: busy=0, done=0, addr_err=0, rdata=0, dm_we=0, dm_addr=0, dm_din=0.
  - Reset during any state aborts the access; dm_we drops immediately, so no partial write.
- States: IDLE, LOAD, READ, WRITE, DONE, ERR. Outputs are Moore, decoded from state and latched request.
- IDLE, on req=1: latch we/op/addr/wdata, then:
  - misaligned (half with addr[0]=1, word with addr[1:0]!=0) or op[1:0]=11 -> ERR
  - else load -> LOAD
  - else sw -> WRITE
  - else sb/sh -> READ
  - req=0 stays IDLE. req is sampled only in IDLE.
- LOAD: dm_addr=addr_q[DM_AW+1:2]; rdata <= extracted, extended dm_dout -> DONE.
- READ: same dm_addr; merge reg <= dm_dout with the selected lane(s) replaced by wdata_q -> WRITE.
- WRITE: dm_we=1; dm_din = wdata_q (sw) or merge reg (sb/sh) -> DONE.
- DONE: done=1, addr_err=0 -> IDLE.
- ERR: done=1, addr_err=1, no memory write -> IDLE. rdata unchanged.
- Byte order is little-endian:
  - byte k = bits [8k+7:8k] selected by addr[1:0]
  - half at addr[1]=0 is [15:0], at addr[1]=1 is [31:16]
- Extension: op[2]=0 sign-extends, op[2]=1 zero-extends; lw ignores op[2].
- Latency from accept edge T:
  - loads and sw: done in cycle T+2
  - sb/sh: done in T+3
  - errors: done in T+1
- busy=1 in every state except IDLE, including DONE.
- Requester must drop or advance req in the DONE cycle. A req still high in the IDLE cycle after DONE is a new access.
- Outside WRITE: dm_we=0 and dm_din holds its last value. dm_addr is don't-care except in LOAD/READ/WRITE.

Optional Feature:
- Macro DM_RANGE_CHECK_EN.
- Defined: a request whose address lies outside [BASE_ADDR, BASE_ADDR + 4*2^DM_AW) also goes to ERR with addr_err=1.
- Undefined: upper address bits are ignored and the address wraps modulo 2^(DM_AW+2) bytes. No range comparator is built.

Decomposition:
- Shared package dm_pkg:
  - op size encodings (SZ_BYTE, SZ_HALF, SZ_WORD)
  - the op[2] unsigned bit position
  - state encoding constants
- One combinational sub-module, dm_lane_unit:
  - load extraction/extension of a word by addr[1:0] and op
  - store lane merge of old word + wdata
  - instantiated once; both functions share the lane decode.

Test Plan:
- Preload word 0x10 = 32'h8899AABB; lb addr 0x13 -> done at T+2, rdata=32'hFFFFFF88. lbu addr 0x12 -> rdata=32'h00000099.
- sh wdata=32'h00001234 to addr 0x12 on that word -> dm_we high exactly one cycle (T+2), word becomes 32'h1234AABB, done at T+3. lw addr 0x10 then returns 32'h1234AABB.
- sw 32'hDEADBEEF to addr 0xFFC -> word 1023 written, busy high T+1..T+2. lh addr 0xFFE -> rdata=32'hFFFFDEAD.
- lw addr 0x21 -> done and addr_err at T+1, dm_we never asserted, rdata unchanged. sh addr 0x21 -> same.
- sb accepted, rst_n pulled low during WRITE before the edge -> dm_we falls immediately, target word unchanged, busy=0, rdata=0.
- DM_RANGE_CHECK_EN defined: lw addr 0x1000 -> addr_err. Undefined: lw addr 0x1000 returns word 0 contents.
